// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle between decode and the immediate-extension stage.
// Carries both the upstream (in_*) and downstream (out_*) channels of one stage.
// master: the environment feeding the stage; slave: the stage itself.
`timescale 1ns/1ps
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator: SEXT / ZEXT / HIGH / BROFF extension of a decode field.
// Latency 1 cycle from accept to out_valid when empty; 1 item/cycle when streaming.
// Backpressure absorbed by a 2-entry (output + skid) buffer; in_ready is registered.
`timescale 1ns/1ps
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int HI_SHIFT = 16,
    parameter int TAG_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    imm_extend_pipe_if.slave   bus
);

    localparam logic [1:0] MODE_SEXT  = 2'b00;
    localparam logic [1:0] MODE_ZEXT  = 2'b01;
    localparam logic [1:0] MODE_HIGH  = 2'b10;
    localparam logic [1:0] MODE_BROFF = 2'b11;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
    } item_t;

    logic             or_vld;
    item_t            or_q;
    logic             sk_vld;
    item_t            sk_q;
    logic             rdy_q;

    logic [OUT_W-1:0] sx;
    logic [OUT_W-1:0] zx;
    logic [OUT_W-1:0] ext;
    item_t            new_item;
    logic             accept;
    logic             consume;

    // Size casts do the extension: a signed operand is sign-extended, an unsigned one zero-filled.
    assign sx = OUT_W'($signed(bus.in_imm));
    assign zx = OUT_W'(bus.in_imm);

    // Select the extension for the incoming item; shifts drop bits past OUT_W.
    always_comb begin
        ext = '0;
        unique case (bus.in_mode)
            MODE_SEXT:  ext = sx;
            MODE_ZEXT:  ext = zx;
            MODE_HIGH:  ext = zx << HI_SHIFT;
            MODE_BROFF: ext = sx << 2;
            default:    ext = '0;
        endcase
    end

    assign new_item.data = ext;
    assign new_item.tag  = bus.in_tag;

    assign accept  = bus.in_valid && rdy_q;
    assign consume = or_vld && bus.out_ready;

    // Output/skid register update. rdy_q tracks "skid will be empty next cycle",
    // so the upstream never sees a combinational path from out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_vld <= 1'b0;
            or_q   <= '0;
            sk_vld <= 1'b0;
            sk_q   <= '0;
            rdy_q  <= 1'b0;
        end else if (flush) begin
            // Squash everything buffered and whatever is being offered this cycle.
            or_vld <= 1'b0;
            sk_vld <= 1'b0;
            rdy_q  <= 1'b1;
        end else begin
            rdy_q <= !sk_vld;
            if (!or_vld || consume) begin
                if (sk_vld) begin
                    // Skid drains first to keep FIFO order; accept cannot fire here.
                    or_q   <= sk_q;
                    or_vld <= 1'b1;
                    sk_vld <= 1'b0;
                    rdy_q  <= 1'b1;
                end else if (accept) begin
                    or_q   <= new_item;
                    or_vld <= 1'b1;
                end else begin
                    or_vld <= 1'b0;
                end
            end else if (accept) begin
                // Output is stalled: park the new item and close the input.
                sk_q   <= new_item;
                sk_vld <= 1'b1;
                rdy_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = or_vld;
    assign bus.out_data  = or_q.data;
    assign bus.out_tag   = or_q.tag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
`timescale 1ns/1ps
module tb_imm_extend_pipe;

    localparam logic [1:0] SEXT  = 2'b00;
    localparam logic [1:0] ZEXT  = 2'b01;
    localparam logic [1:0] HIGH  = 2'b10;
    localparam logic [1:0] BROFF = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush0;
    logic flush1;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) b0 ();
    imm_extend_pipe_if #(.IN_W(12), .OUT_W(16), .TAG_W(5)) b1 ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .HI_SHIFT(16), .TAG_W(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0), .bus(b0.slave)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(16), .HI_SHIFT(4), .TAG_W(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .bus(b1.slave)
    );

    int tests = 0;
    int fails = 0;
    int stall0 = 0;

    logic [31:0] q0_d[$];
    logic [4:0]  q0_t[$];
    logic [15:0] q1_d[$];
    logic [4:0]  q1_t[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop and compare whenever an output transfer is about to complete.
    always @(negedge clk) begin
        if (rst_n && b0.out_valid && b0.out_ready) begin
            if (q0_d.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon0_unexpected: got data %h tag %0d, expected no item", b0.out_data, b0.out_tag);
            end else begin
                chk("mon0_data", b0.out_data, q0_d.pop_front());
                chk("mon0_tag", 32'(b0.out_tag), 32'(q0_t.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b1.out_valid && b1.out_ready) begin
            if (q1_d.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon1_unexpected: got data %h tag %0d, expected no item", b1.out_data, b1.out_tag);
            end else begin
                chk("mon1_data", 32'(b1.out_data), 32'(q1_d.pop_front()));
                chk("mon1_tag", 32'(b1.out_tag), 32'(q1_t.pop_front()));
            end
        end
    end

    // Offer one item to dut0 (called at posedge+1); returns at posedge+1 after it is accepted.
    task automatic send0(input logic [15:0] imm, input logic [1:0] mode,
                         input logic [4:0] tag, input logic [31:0] exp);
        bit got = 1'b0;
        b0.in_valid = 1'b1;
        b0.in_imm   = imm;
        b0.in_mode  = mode;
        b0.in_tag   = tag;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (b0.in_ready) begin
                q0_d.push_back(exp);
                q0_t.push_back(tag);
                got = 1'b1;
            end else begin
                stall0++;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL send0_timeout: got no accept for imm %h, expected accept within 50 cycles", imm);
        end
    endtask

    task automatic send1(input logic [11:0] imm, input logic [1:0] mode,
                         input logic [4:0] tag, input logic [15:0] exp);
        bit got = 1'b0;
        b1.in_valid = 1'b1;
        b1.in_imm   = imm;
        b1.in_mode  = mode;
        b1.in_tag   = tag;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (b1.in_ready) begin
                q1_d.push_back(exp);
                q1_t.push_back(tag);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL send1_timeout: got no accept for imm %h, expected accept within 50 cycles", imm);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [15:0] s_imm [8];
    logic [1:0]  s_mode[8];
    logic [31:0] s_exp [8];

    initial begin
        #200000;
        fails++;
        $display("FAIL global_timeout: got no finish, expected finish before 200us");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        s_imm  = '{16'h8000, 16'hFFFF, 16'hABCD, 16'h0001, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000};
        s_mode = '{SEXT, ZEXT, HIGH, BROFF, SEXT, ZEXT, HIGH, BROFF};
        s_exp  = '{32'hFFFF8000, 32'h0000FFFF, 32'hABCD0000, 32'h00000004,
                   32'h00007FFF, 32'h00000000, 32'hFFFF0000, 32'hFFFE0000};

        rst_n = 1'b0;
        flush0 = 1'b0;
        flush1 = 1'b0;
        b0.in_valid = 1'b0; b0.in_imm = '0; b0.in_mode = SEXT; b0.in_tag = '0; b0.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_imm = '0; b1.in_mode = SEXT; b1.in_tag = '0; b1.out_ready = 1'b0;

        // Reset state
        idle(2);
        @(negedge clk);
        chk1("rst_out_valid", b0.out_valid, 1'b0);
        chk("rst_out_data", b0.out_data, 32'h0);
        chk("rst_out_tag", 32'(b0.out_tag), 32'h0);
        chk1("rst_in_ready", b0.in_ready, 1'b0);
        chk1("rst_in_ready1", b1.in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        @(negedge clk);
        chk1("post_rst_in_ready", b0.in_ready, 1'b1);
        @(posedge clk); #1;

        // Defaults and single-item latency
        b0.out_ready = 1'b1;
        send0(16'h8241, SEXT, 5'd7, 32'hFFFF8241);
        b0.in_valid = 1'b0;
        @(negedge clk);
        chk1("latency_out_valid", b0.out_valid, 1'b1);
        @(posedge clk); #1;
        send0(16'h4241, SEXT, 5'd3, 32'h00004241);
        send0(16'h8241, ZEXT, 5'd4, 32'h00008241);
        send0(16'h1234, HIGH, 5'd5, 32'h12340000);
        send0(16'hFFFF, BROFF, 5'd6, 32'hFFFFFFFC);
        send0(16'h7FFF, BROFF, 5'd8, 32'h0001FFFC);
        b0.in_valid = 1'b0;
        idle(3);

        // Backpressure: A to output reg, B to skid, C held at the input
        b0.out_ready = 1'b0;
        send0(16'h0011, SEXT, 5'd1, 32'h00000011);
        send0(16'h8022, ZEXT, 5'd2, 32'h00008022);
        @(negedge clk);
        chk1("bp_in_ready_low", b0.in_ready, 1'b0);
        chk("bp_hold_data", b0.out_data, 32'h00000011);
        chk("bp_hold_tag", 32'(b0.out_tag), 32'd1);
        @(posedge clk); #1;
        fork
            begin
                send0(16'h0033, HIGH, 5'd3, 32'h00330000);
                b0.in_valid = 1'b0;
            end
            begin
                repeat (2) begin
                    @(negedge clk);
                    chk1("bp_c_held", b0.in_ready, 1'b0);
                    chk("bp_stable_data", b0.out_data, 32'h00000011);
                end
                @(posedge clk); #1;
                b0.out_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk1("bp_drain_valid", b0.out_valid, 1'b1);
                end
            end
        join
        @(posedge clk); #1;
        idle(2);

        // Streaming at full rate
        stall0 = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send0(s_imm[i], s_mode[i], 5'(10 + i), s_exp[i]);
                b0.in_valid = 1'b0;
            end
            begin
                int run = 0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (b0.out_valid) run++;
                    else if (run > 0) break;
                end
                chk("stream_run", 32'(run), 32'd8);
            end
        join
        chk("stream_no_stall", 32'(stall0), 32'd0);
        @(posedge clk); #1;

        // Flush with both registers full and a new item offered
        b0.out_ready = 1'b0;
        send0(16'h0101, SEXT, 5'd20, 32'h00000101);
        send0(16'h0202, SEXT, 5'd21, 32'h00000202);
        b0.in_valid = 1'b1; b0.in_imm = 16'h0303; b0.in_tag = 5'd24;
        flush0 = 1'b1;
        @(posedge clk); #1;
        flush0 = 1'b0;
        b0.in_valid = 1'b0;
        q0_d.delete(); q0_t.delete();
        @(negedge clk);
        chk1("flush_out_valid", b0.out_valid, 1'b0);
        chk1("flush_in_ready", b0.in_ready, 1'b1);
        @(posedge clk); #1;
        b0.out_ready = 1'b1;
        idle(3);

        // Flush while in_ready=1: the offered item must be discarded
        b0.out_ready = 1'b0;
        send0(16'h0404, SEXT, 5'd22, 32'h00000404);
        b0.in_valid = 1'b1; b0.in_imm = 16'h0505; b0.in_tag = 5'd25;
        flush0 = 1'b1;
        @(posedge clk); #1;
        flush0 = 1'b0;
        b0.in_valid = 1'b0;
        q0_d.delete(); q0_t.delete();
        @(negedge clk);
        chk1("flush2_out_valid", b0.out_valid, 1'b0);
        chk1("flush2_in_ready", b0.in_ready, 1'b1);
        @(posedge clk); #1;
        b0.out_ready = 1'b1;
        idle(3);
        send0(16'h0606, ZEXT, 5'd23, 32'h00000606);
        b0.in_valid = 1'b0;
        idle(3);

        // Reset mid-stream
        b0.out_ready = 1'b0;
        send0(16'h0707, SEXT, 5'd26, 32'h00000707);
        send0(16'h0808, SEXT, 5'd27, 32'h00000808);
        b0.in_valid = 1'b1; b0.in_imm = 16'h0909;
        rst_n = 1'b0;
        @(posedge clk); #1;
        q0_d.delete(); q0_t.delete();
        @(negedge clk);
        chk1("mid_rst_out_valid", b0.out_valid, 1'b0);
        chk("mid_rst_out_data", b0.out_data, 32'h0);
        chk("mid_rst_out_tag", 32'(b0.out_tag), 32'h0);
        chk1("mid_rst_in_ready", b0.in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        b0.in_valid = 1'b0;
        b0.out_ready = 1'b1;
        idle(1);
        @(negedge clk);
        chk1("mid_rst_release_ready", b0.in_ready, 1'b1);
        chk1("mid_rst_release_valid", b0.out_valid, 1'b0);
        @(posedge clk); #1;

        // Parametric instance IN_W=12, OUT_W=16, HI_SHIFT=4
        b1.out_ready = 1'b1;
        send1(12'h800, SEXT, 5'd1, 16'hF800);
        send1(12'h800, ZEXT, 5'd2, 16'h0800);
        send1(12'hABC, HIGH, 5'd3, 16'hABC0);
        send1(12'hFFF, BROFF, 5'd4, 16'hFFFC);
        b1.in_valid = 1'b0;

        for (int k = 0; k < 50 && (q0_d.size() != 0 || q1_d.size() != 0); k++)
            @(negedge clk);
        chk("drain_q0", 32'(q0_d.size()), 32'd0);
        chk("drain_q1", 32'(q1_d.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
